// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipeline_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WAIT  = 2'b01,
      ERROR = 2'b10
   } ctrl_state_t;

   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

   // A producer supplies a source only if it writes a real register (x0 never forwards).
   function automatic logic reg_hit(input logic [4:0] rd, input logic we, input logic [4:0] rs);
      return we && (rd != 5'd0) && (rd == rs);
   endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one Execute-stage source; Memory wins over Writeback.
module fwd_select
   import pipeline_pkg::*;
(
   input  logic [4:0] rs_i,
   input  logic [4:0] m_rd_i,
   input  logic       m_we_i,
   input  logic [4:0] w_rd_i,
   input  logic       w_we_i,
   output logic [1:0] sel_o
);

   always_comb begin
      sel_o = FWD_RF;
      if (reg_hit(m_rd_i, m_we_i, rs_i)) begin
         sel_o = FWD_M;
      end else if (reg_hit(w_rd_i, w_we_i, rs_i)) begin
         sel_o = FWD_W;
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller: stall/flush priority, memory-wait FSM with
// timeout watchdog, forwarding selects and saturating performance counters.
//
// state | meaning
// IDLE  | no outstanding memory wait; a new unready access starts one
// WAIT  | data-memory access outstanding, pipeline frozen until mem_ready
// ERROR | wait exceeded TIMEOUT; pipeline frozen until rst
module pipeline_ctrl
   import pipeline_pkg::*;
#(
   parameter int TIMEOUT   = 255,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [4:0]           D_rs1,
   input  logic [4:0]           D_rs2,
   input  logic [4:0]           E_rs1,
   input  logic [4:0]           E_rs2,
   input  logic [4:0]           E_rd,
   input  logic [1:0]           E_result_src,
   input  logic                 E_PCSrc,
   input  logic [4:0]           M_rd,
   input  logic                 M_RegWrite,
   input  logic [4:0]           W_rd,
   input  logic                 W_RegWrite,
   input  logic                 M_mem_access,
   input  logic                 mem_ready,
   output logic                 stall_F,
   output logic                 stall_D,
   output logic                 stall_E,
   output logic                 stall_M,
   output logic                 flush_D,
   output logic                 flush_E,
   output logic                 bubble_W,
   output logic [1:0]           fwdA,
   output logic [1:0]           fwdB,
   output logic                 mem_err,
   output logic [CNT_WIDTH-1:0] stall_cnt,
   output logic [CNT_WIDTH-1:0] flush_cnt
);

   localparam int WCW = $clog2(TIMEOUT + 1);

   ctrl_state_t          state_q, state_d;
   logic [WCW-1:0]       wait_cnt_q, wait_cnt_d;
   logic                 mem_err_q, mem_err_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
   logic                 mem_stall;
   logic                 load_use;
   logic [1:0]           fwd_a, fwd_b;

   fwd_select u_fwd_a (
      .rs_i   (E_rs1),
      .m_rd_i (M_rd),
      .m_we_i (M_RegWrite),
      .w_rd_i (W_rd),
      .w_we_i (W_RegWrite),
      .sel_o  (fwd_a)
   );

   fwd_select u_fwd_b (
      .rs_i   (E_rs2),
      .m_rd_i (M_rd),
      .m_we_i (M_RegWrite),
      .w_rd_i (W_rd),
      .w_we_i (W_RegWrite),
      .sel_o  (fwd_b)
   );

   assign fwdA = rst ? FWD_RF : fwd_a;
   assign fwdB = rst ? FWD_RF : fwd_b;

   assign load_use = (E_result_src == RESULT_SRC_LOAD) && (E_rd != 5'd0) &&
                     ((E_rd == D_rs1) || (E_rd == D_rs2));

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_stall  = 1'b0;
      unique case (state_q)
         IDLE: begin
            mem_stall = M_mem_access & ~mem_ready;
            if (mem_stall) begin
               state_d    = WAIT;
               wait_cnt_d = WCW'(1);
            end
         end
         WAIT: begin
            mem_stall = ~mem_ready;
            if (mem_ready) begin
               state_d    = IDLE;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WCW'(TIMEOUT)) begin
               state_d = ERROR;
            end else begin
               wait_cnt_d = wait_cnt_q + WCW'(1);
            end
         end
         ERROR: begin
            mem_stall = 1'b1;
         end
         default: begin
            state_d    = IDLE;
            wait_cnt_d = '0;
         end
      endcase
   end

   // Freeze beats branch beats load-use; E holds while frozen, so both re-evaluate on release.
   always_comb begin
      stall_F  = 1'b0;
      stall_D  = 1'b0;
      stall_E  = 1'b0;
      stall_M  = 1'b0;
      flush_D  = 1'b0;
      flush_E  = 1'b0;
      bubble_W = 1'b0;
      if (!rst) begin
         if (mem_stall) begin
            stall_F  = 1'b1;
            stall_D  = 1'b1;
            stall_E  = 1'b1;
            stall_M  = 1'b1;
            bubble_W = 1'b1;
         end else if (E_PCSrc) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
         end else if (load_use) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
         end
      end
   end

   always_comb begin
      mem_err_d   = mem_err_q | (state_d == ERROR);
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_F && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      end
      if (flush_D && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign mem_err   = mem_err_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
